// File: rtl/axil_master_if.sv
// Command/response port plus AXI4-Lite channels for axil_master.
// master: the initiator's view; slave: the view of the bus and command source around it.
interface axil_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
               awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready
    );
endinterface

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one command in, one AXI-Lite transaction out, one response back.
// Optional watchdog abort enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic          aclk,
    input  logic          areset,
    axil_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic        bready_q, bready_d, rready_q, rready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic        aw_done, w_done;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          busy;
`endif

    // A channel counts as done once its valid has been accepted (now or earlier).
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q  || bus.wready;

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                if (bus.cmd_we) begin
                    awaddr_d  = bus.cmd_addr;
                    wdata_d   = bus.cmd_wdata;
                    wstrb_d   = bus.cmd_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = WR_AW_W;
                end else begin
                    araddr_d  = bus.cmd_addr;
                    arvalid_d = 1'b1;
                    state_d   = RD_AR;
                end
            end
            WR_AW_W: begin
                if (awvalid_q && bus.awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: if (bus.bvalid) begin
                bready_d    = 1'b0;
                rsp_resp_d  = bus.bresp;
                rsp_rdata_d = '0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RD_AR: if (bus.arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_R;
            end
            RD_R: if (bus.rvalid) begin
                rready_d    = 1'b0;
                rsp_rdata_d = bus.rdata;
                rsp_resp_d  = bus.rresp;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
                rsp_timeout_d = 1'b0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
        busy = (state_q == WR_AW_W) || (state_q == WR_B) ||
               (state_q == RD_AR) || (state_q == RD_R);
        if (state_q == IDLE) cnt_d = '0;
        else if (busy)       cnt_d = cnt_q + 1'b1;
        // Watchdog abort wins over any handshake completing in the same cycle.
        if (busy && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_resp_d    = 2'b11;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
        end
`endif
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.awaddr    = awaddr_q;
    assign bus.awprot    = 3'b000;
    assign bus.awvalid   = awvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wvalid    = wvalid_q;
    assign bus.bready    = bready_q;
    assign bus.araddr    = araddr_q;
    assign bus.arprot    = 3'b000;
    assign bus.arvalid   = arvalid_q;
    assign bus.rready    = rready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: reactive AXI-Lite slave model plus response scoreboard.
module tb_axil_master;
    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    // slave model configuration
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
    logic [31:0] r_data = '0;
    bit          b_hold = 0, r_early = 0;

    // monitor state
    int          aw_c = 0, w_c = 0, ar_c = 0;
    int          aw_hi = 0, w_hi = 0, ar_hi = 0, r_hi = 0, rsp_rise = 0, aw_unstable = 0;
    bit          aw_prev_v = 0, rsp_prev = 0;
    logic [31:0] aw_prev_a = '0;

    axil_master_if bus();

    axil_master #(.TIMEOUT_CYCLES(16)) dut (
        .aclk   (clk),
        .areset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Slave model and monitors, evaluated away from the active edge.
    always @(negedge clk) begin
        if (bus.awvalid) begin
            bus.awready = (aw_c >= aw_lat); aw_c++; aw_hi++;
            if (aw_prev_v && bus.awaddr !== aw_prev_a) aw_unstable++;
        end else begin
            bus.awready = 1'b0; aw_c = 0;
        end
        aw_prev_v = bus.awvalid; aw_prev_a = bus.awaddr;
        if (bus.wvalid) begin bus.wready = (w_c >= w_lat); w_c++; w_hi++; end
        else begin bus.wready = 1'b0; w_c = 0; end
        if (bus.arvalid) begin bus.arready = (ar_c >= ar_lat); ar_c++; ar_hi++; end
        else begin bus.arready = 1'b0; ar_c = 0; end
        bus.bvalid = bus.bready && !b_hold;
        bus.bresp  = b_resp;
        bus.rvalid = bus.rready || r_early;
        bus.rdata  = r_data;
        bus.rresp  = r_resp;
        if (bus.rready) r_hi++;
        if (bus.rsp_valid && !rsp_prev) rsp_rise++;
        rsp_prev = bus.rsp_valid;
    end

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input rsp_t e);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = a;
        bus.cmd_wdata = d; bus.cmd_wstrb = s;
        sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 60) begin @(negedge clk); n++; end
    endtask

    task automatic release_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
             bus.rsp_valid, bus.rsp_timeout} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0", {bus.awvalid, bus.wvalid,
                bus.arvalid, bus.bready, bus.rready, bus.rsp_valid, bus.rsp_timeout});
        end
        checks++;
        if ({bus.awaddr, bus.wdata, bus.wstrb, bus.araddr, bus.rsp_rdata, bus.rsp_resp,
             bus.awprot, bus.arprot} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h exp 0", bus.awaddr, bus.wdata, bus.rsp_rdata);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        int n; rsp_t got, exp;
        aw_lat = 0; w_lat = 0; b_resp = 2'b00;
        issue(1'b1, 32'h0, 32'h1, 4'hF, '{32'h0, 2'b00, 1'b0});
        checks++;
        if (!(bus.awvalid && bus.wvalid) || bus.awaddr !== 32'h0 || bus.wdata !== 32'h1 || bus.wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_aw_w_issue got v=%b%b a=%h d=%h s=%h exp v=11 a=0 d=1 s=f",
                bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata, bus.wstrb);
        end
        wait_rsp(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", n); end
        got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}; exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wr_basic_rsp got %h exp %h", got, exp); end
        release_rsp();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL wr_return_idle got rdy=%b vld=%b exp 1/0", bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_aw_delay();
        int n, aw0, w0, un0, rr0; rsp_t got, exp;
        aw_lat = 3; w_lat = 0;
        aw0 = aw_hi; w0 = w_hi; un0 = aw_unstable; rr0 = rsp_rise;
        issue(1'b1, 32'h4, 32'h0000_0055, 4'hF, '{32'h0, 2'b00, 1'b0});
        checks++;
        if (bus.awaddr !== 32'h4) begin errors++; $display("FAIL awdly_addr got %h exp 4", bus.awaddr); end
        wait_rsp(n);
        checks++;
        if (!bus.rsp_valid) begin errors++; $display("FAIL awdly_wait got no rsp exp rsp"); end
        got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}; exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL awdly_rsp got %h exp %h", got, exp); end
        release_rsp();
        repeat (3) @(negedge clk);
        checks++;
        if (aw_hi - aw0 !== 4) begin errors++; $display("FAIL awdly_awvalid_cycles got %0d exp 4", aw_hi - aw0); end
        checks++;
        if (w_hi - w0 !== 1) begin errors++; $display("FAIL awdly_wvalid_cycles got %0d exp 1", w_hi - w0); end
        checks++;
        if (aw_unstable !== un0) begin errors++; $display("FAIL awdly_addr_stable got %0d changes exp 0", aw_unstable - un0); end
        checks++;
        if (rsp_rise - rr0 !== 1) begin errors++; $display("FAIL awdly_single_rsp got %0d exp 1", rsp_rise - rr0); end
        aw_lat = 0;
    endtask

    task automatic test_read_basic();
        int n, r0; rsp_t got, exp;
        ar_lat = 2; r_early = 1; r_data = 32'h0000_00A5; r_resp = 2'b00;
        r0 = r_hi;
        issue(1'b0, 32'h4, 32'h0, 4'h0, '{32'h0000_00A5, 2'b00, 1'b0});
        checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h4) begin
            errors++; $display("FAIL rd_ar_issue got v=%b a=%h exp 1/4", bus.arvalid, bus.araddr);
        end
        wait_rsp(n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL rd_early_rvalid_latency got %0d exp 4", n); end
        got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}; exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rd_basic_rsp got %h exp %h", got, exp); end
        checks++;
        if (r_hi - r0 !== 1) begin errors++; $display("FAIL rd_rready_cycles got %0d exp 1", r_hi - r0); end
        release_rsp();
        ar_lat = 0; r_early = 0;
    endtask

    task automatic test_slverr_hold();
        int n; rsp_t got, exp;
        r_data = 32'h1234_5678; r_resp = 2'b10;
        issue(1'b0, 32'h8, 32'h0, 4'h0, '{32'h1234_5678, 2'b10, 1'b0});
        wait_rsp(n);
        exp = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout};
            checks++;
            if (bus.rsp_valid !== 1'b1 || got !== exp) begin
                errors++; $display("FAIL slverr_hold[%0d] got v=%b %h exp v=1 %h", i, bus.rsp_valid, got, exp);
            end
            checks++;
            if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL slverr_cmd_ready[%0d] got %b exp 0", i, bus.cmd_ready); end
            @(negedge clk);
        end
        release_rsp();
        r_resp = 2'b00;
    endtask

    task automatic test_reset_mid();
        int n, rr0;
        b_hold = 1; rr0 = rsp_rise;
        issue(1'b1, 32'h4, 32'hCAFE_0001, 4'hF, '{32'h0, 2'b00, 1'b0});
        n = 0;
        while (!bus.bready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (bus.bready !== 1'b1) begin errors++; $display("FAIL rstmid_reach_wr_b got bready=%b exp 1", bus.bready); end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.bready, bus.awvalid, bus.wvalid, bus.rsp_valid} !== 4'b0) begin
            errors++; $display("FAIL rstmid_async_drop got %b exp 0000", {bus.bready, bus.awvalid, bus.wvalid, bus.rsp_valid});
        end
        @(negedge clk); rst = 1'b0; b_hold = 0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got %b exp 1", bus.cmd_ready); end
        repeat (4) @(negedge clk);
        checks++;
        if (rsp_rise !== rr0) begin errors++; $display("FAIL rstmid_no_rsp got %0d rsp exp 0", rsp_rise - rr0); end
    endtask

    task automatic test_back_to_back();
        int n; rsp_t got, exp;
        b_resp = 2'b10;
        issue(1'b1, 32'h0, 32'hDEAD_BEEF, 4'h3, '{32'h0, 2'b10, 1'b0});
        checks++;
        if (bus.wdata !== 32'hDEAD_BEEF || bus.wstrb !== 4'h3) begin
            errors++; $display("FAIL b2b_wdata got %h/%h exp deadbeef/3", bus.wdata, bus.wstrb);
        end
        wait_rsp(n);
        got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}; exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_wr_rsp got %h exp %h", got, exp); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        b_resp = 2'b00;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_cmd_ready got %b exp 1", bus.cmd_ready); end
        r_data = 32'h0BAD_F00D;
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h0;
        sb.push_back('{32'h0BAD_F00D, 2'b00, 1'b0});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_rsp(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL b2b_rd_latency got %0d exp 2", n); end
        got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}; exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_rd_rsp got %h exp %h", got, exp); end
        release_rsp();
    endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int n, a0; rsp_t got, exp;
        ar_lat = 1000; a0 = ar_hi;
        issue(1'b0, 32'h10, 32'h0, 4'h0, '{32'h0, 2'b11, 1'b1});
        wait_rsp(n);
        got = {bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}; exp = sb.pop_front();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL timeout_rsp got %h exp %h", got, exp); end
        checks++;
        if (ar_hi - a0 !== 16) begin errors++; $display("FAIL timeout_arvalid_cycles got %0d exp 16", ar_hi - a0); end
        release_rsp();
        ar_lat = 0;
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_write_basic();
        test_aw_delay();
        test_read_basic();
        test_slverr_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef AXIL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog got no finish exp finish");
        $fatal(1, "simulation time limit");
    end
endmodule
